ping_pong_seg_display: RTL
==========================

# ping_pong_seg_display

Four-digit, time-multiplexed seven-segment driver that sits directly downstream of the ping-pong counter on the FPGA top level. It captures the counter's 4-bit value and direction on an update strobe, then shows the value as two decimal digits and the direction as a two-digit arrow glyph. All outputs are registered and active-low to match the board's common-anode display.

## Interface

- SCAN_PERIOD, default 100000: clk cycles each digit stays selected; legal range ≥ 2.
- CNT_W, default 17: width of the scan counter; must satisfy 2^CNT_W ≥ SCAN_PERIOD.

- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- upd  in  1  capture strobe; value/direction latched on a clk edge where upd=1
- value  in  4  counter value to display, 0..15
- direction  in  1  1 = counting up, 0 = counting down
- an  out  4  digit enables, active-low; an[3] leftmost
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g

## Operation

- Latch registers: lat_val (4b), lat_dir (1b). Loaded on upd=1, otherwise held. upd is level-sampled every edge; holding upd high tracks value continuously.
- Scan counter scnt: counts 0..SCAN_PERIOD-1, then wraps to 0. On the wrap edge, digit index idx (2b) advances 0→1→2→3→0.
- Output registers are loaded every edge from current idx, lat_val and lat_dir:
  - idx 3: an=4'b0111, tens digit = (lat_val ≥ 10) ? 1 : 0.
  - idx 2: an=4'b1011, units digit = (lat_val ≥ 10) ? lat_val−10 : lat_val.
  - idx 1 and idx 0: an=4'b1101 / 4'b1110, direction glyph.
    - lat_dir=1: up glyph, segments a,b,f,g lit.
    - lat_dir=0: down glyph, segments c,d,e,g lit.
- Decimal decoder: standard 0–9 patterns. 7 lights a,b,c; 9 lights a,b,c,d,f,g. Codes outside 0–9 cannot occur after the split.
- Exactly one an bit is low at any time after the first post-reset edge.
- Reset (rst_n=0 at an edge):
  - scnt=0, idx=0, lat_val=0, lat_dir=1.
  - an=4'b1111 (all digits off), seg=7'b1111111.
  - Reset overrides upd.
  - Reset mid-scan restarts at idx 0 with a full SCAN_PERIOD dwell.

## Timing

- Outputs change only on clk rising edges. No combinational path from inputs to outputs.
- First edge with rst_n=1: an=4'b1110, seg shows the glyph for lat_dir=1.
- upd at edge t: latch updates at t. seg for the active digit reflects the new value at edge t+1, which is 1 cycle of latency.
- idx advances on the wrap edge. an/seg for the new digit appear on the following edge, so each digit is shown for exactly SCAN_PERIOD cycles; the full frame is 4×SCAN_PERIOD.
- upd coinciding with a wrap edge: both take effect. The new digit is shown with the new latched value.
- upd with unchanged value/direction produces no visible change.

## Configuration

- SEG_LEADING_ZERO_BLANK_EN
  - Defined: when lat_val < 10, the idx 3 slot drives seg=7'b1111111 (blank). an timing is unchanged.
  - Undefined: the tens digit shows "0" for lat_val < 10.

## Test plan

- Reset with SCAN_PERIOD=4: hold rst_n=0 for 3 cycles → an=4'b1111, seg=7'h7F. First edge after release → an=4'b1110, up glyph (a,b,f,g lit). Running 16 cycles → an sequence 1110,1101,1011,0111, each held 4 cycles.
- upd=1 with value=13, direction=1 → idx 3 shows "1", idx 2 shows "3", idx 1/0 show the up glyph. Then value changes to 14 with upd=0 → display stays at 13.
- upd=1 with value=7, direction=0 → idx 2 shows "7" (a,b,c lit) and idx 1/0 show the down glyph. idx 3 shows "0" with the macro undefined, or blank (7'h7F) with SEG_LEADING_ZERO_BLANK_EN.
- Sweep value 0..15 with upd pulsed each frame → the tens/units split is correct at every value, including the boundaries 9→10 and 15.
- Assert rst_n=0 mid-dwell at idx 2 → the next edge gives an=4'b1111. After release, scanning restarts at idx 0, lat_val=0, lat_dir=1.
- Pulse upd exactly on a scan-wrap edge → the new digit's first displayed cycle already uses the new value. an never has two bits low in the same cycle.

Source files
------------

// File: rtl/ping_pong_seg_display_if.sv
// ---------------------------------------------------------------------------
// ping_pong_seg_display_if
// Groups the counter-to-display signals of the ping-pong seven-segment driver.
//   upd       : capture strobe, value/direction latched on a clk edge with upd=1
//   value     : 4-bit counter value, 0..15
//   direction : 1 = counting up, 0 = counting down
//   an        : digit enables, active-low, an[3] leftmost
//   seg       : segments, active-low, seg[0]=a .. seg[6]=g
// master : the side producing value/direction (counter or testbench)
// slave  : the display driver
// ---------------------------------------------------------------------------
interface ping_pong_seg_display_if;
  logic       upd;
  logic [3:0] value;
  logic       direction;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (
    output upd,
    output value,
    output direction,
    input  an,
    input  seg
  );

  modport slave (
    input  upd,
    input  value,
    input  direction,
    output an,
    output seg
  );
endinterface

// File: rtl/ping_pong_seg_display.sv
// ---------------------------------------------------------------------------
// ping_pong_seg_display
// Four-digit time-multiplexed seven-segment driver for the ping-pong counter.
// Latches the counter value and direction on an update strobe and shows the
// value as two decimal digits (left pair) and the direction as a two-digit
// arrow glyph (right pair). All outputs are registered and active-low for a
// common-anode display.
//
// Parameters:
//   SCAN_PERIOD : clk cycles each digit stays selected (>= 2)
//   CNT_W       : scan counter width, 2**CNT_W >= SCAN_PERIOD
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of ping_pong_seg_display_if (upd/value/direction in,
//           an/seg out)
// Configuration macro:
//   SEG_LEADING_ZERO_BLANK_EN : when defined, the tens digit is blanked for
//                               values below 10 instead of showing "0".
// ---------------------------------------------------------------------------
module ping_pong_seg_display #(
  parameter int SCAN_PERIOD = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ping_pong_seg_display_if.slave  bus
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);

  // Active-low glyphs for the direction arrow (up: a,b,f,g; down: c,d,e,g)
  localparam logic [6:0] SEG_UP    = 7'b0011100;
  localparam logic [6:0] SEG_DOWN  = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIGIT0 = 2'd0,
    DIGIT1 = 2'd1,
    DIGIT2 = 2'd2,
    DIGIT3 = 2'd3
  } digit_t;

  digit_t           r_idx;
  digit_t           w_idxNext;
  logic [CNT_W-1:0] r_scnt;
  logic             w_wrap;
  logic [3:0]       r_latVal;
  logic             r_latDir;
  logic [3:0]       w_units;
  logic             w_tensIsOne;
  logic [3:0]       w_anNext;
  logic [6:0]       w_segNext;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  // Active-low decimal decoder; codes above 9 never reach it after the split.
  function automatic logic [6:0] decodeDigit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Capture the counter value; reset leaves the display showing 0 counting up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_latVal <= 4'd0;
      r_latDir <= 1'b1;
    end else if (bus.upd) begin
      r_latVal <= bus.value;
      r_latDir <= bus.direction;
    end
  end

  // Dwell counter for the currently selected digit.
  assign w_wrap = (r_scnt == SCAN_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scnt <= '0;
    end else if (w_wrap) begin
      r_scnt <= '0;
    end else begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  // Digit-select state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= DIGIT0;
    end else begin
      r_idx <= w_idxNext;
    end
  end

  // Advance to the next digit only when the dwell counter wraps.
  always_comb begin
    w_idxNext = r_idx;
    if (w_wrap) begin
      case (r_idx)
        DIGIT0:  w_idxNext = DIGIT1;
        DIGIT1:  w_idxNext = DIGIT2;
        DIGIT2:  w_idxNext = DIGIT3;
        DIGIT3:  w_idxNext = DIGIT0;
        default: w_idxNext = DIGIT0;
      endcase
    end
  end

  // Tens/units split; the value never exceeds 15 so tens is 0 or 1.
  assign w_tensIsOne = (r_latVal >= 4'd10);
  assign w_units     = w_tensIsOne ? (r_latVal - 4'd10) : r_latVal;

  // Next an/seg from the current digit and latched data; registered below so
  // the new digit appears one edge after the index changes.
  always_comb begin
    w_anNext  = 4'b1111;
    w_segNext = SEG_BLANK;
    case (r_idx)
      DIGIT3: begin
        w_anNext = 4'b0111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_segNext = w_tensIsOne ? decodeDigit(4'd1) : SEG_BLANK;
`else
        w_segNext = w_tensIsOne ? decodeDigit(4'd1) : decodeDigit(4'd0);
`endif
      end
      DIGIT2: begin
        w_anNext  = 4'b1011;
        w_segNext = decodeDigit(w_units);
      end
      DIGIT1: begin
        w_anNext  = 4'b1101;
        w_segNext = r_latDir ? SEG_UP : SEG_DOWN;
      end
      DIGIT0: begin
        w_anNext  = 4'b1110;
        w_segNext = r_latDir ? SEG_UP : SEG_DOWN;
      end
      default: begin
        w_anNext  = 4'b1111;
        w_segNext = SEG_BLANK;
      end
    endcase
  end

  // Output registers: all digits dark during reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;

endmodule
